alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 4-bit two-operand arithmetic/logic unit with 8 operations selected by a 3-bit opcode.
- Produces an 8-bit result, registered one cycle after a valid input is accepted.
- Sits in datapath lab designs as a leaf compute block fed by a controller or bench.

Parameters:
- WIDTH, 4, operand width; result width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- sel  input  3  opcode.
- in_valid  input  1  inputs are sampled on a rising clk edge when high.
- Y  output  2*WIDTH  registered result.
- out_valid  output  1  high for exactly one cycle when Y is updated.

Behaviour:
- Reset: asynchronous on rst high. Y=0 and out_valid=0 immediately. Both are held while rst is high. Normal operation resumes at the first clk edge after rst falls.
- Latency: 1 cycle. On a clk edge with in_valid=1, Y is loaded with f(A,B,sel) and out_valid is set to 1. On an edge with in_valid=0, Y holds its value and out_valid is set to 0.
- No backpressure. A new operation may be issued every cycle; back-to-back results stream out.
- Opcodes (all results are 2*WIDTH bits; "zero-extended" means upper WIDTH bits are 0):
  - 000 ADD: A+B, zero-extended. The carry lands in bit WIDTH.
  - 001 SUB: A-B in 2*WIDTH-bit two's complement. Example: 3-6 = 8'hFD.
  - 010 AND: A&B, zero-extended.
  - 011 OR: A|B, zero-extended.
  - 100 XOR: A^B, zero-extended.
  - 101 NOT: ~A (bitwise, WIDTH bits), zero-extended. B is ignored.
  - 110 MUL: unsigned A*B, full 2*WIDTH-bit product. No overflow is possible.
  - 111 CMP: unsigned compare. Y[0]=(A>B), Y[1]=(A==B), Y[2]=(A<B); all other bits are 0. Exactly one of bits 0..2 is set.
- Boundaries:
  - Max operands (A=B=4'hF): ADD=8'h1E, MUL=8'hE1.
  - Zero operands: MUL=0, CMP=8'h02.
  - Reset asserted while in_valid is high aborts the operation; no out_valid pulse is produced for it.
  - X/Z on A, B or sel while in_valid=0 must not affect Y.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, three registered outputs are added, updated on the same edge and under the same conditions as Y, and reset to 0:
  - zero (1): Y==0.
  - carry (1): for ADD, bit WIDTH of the sum; for SUB, the borrow (A<B); 0 for all other ops.
  - neg (1): MSB of Y.
- When undefined, these ports and their logic are absent, and the port list is exactly as listed above.

Test Plan:
- Reset: assert rst mid-cycle with in_valid=1 -> Y=0 and out_valid=0 immediately, with no pulse after release.
- A=6, B=3, sweep sel 000..111 one per cycle with in_valid=1 -> Y sequence 8'h09, 8'h03, 8'h02, 8'h07, 8'h05, 8'h09, 8'h12, 8'h01. out_valid is high each cycle, one cycle after issue.
- A=3, B=6: SUB -> 8'hFD; CMP -> 8'h04. With flags enabled, SUB gives carry=1, neg=1.
- A=F, B=F: ADD -> 8'h1E (carry=1); MUL -> 8'hE1; CMP -> 8'h02; XOR -> 8'h00 (zero=1).
- in_valid=0 for 3 cycles after a result -> Y holds its value and out_valid=0. Toggling A/B/sel during this time has no effect.
- Back-to-back: MUL 5*7 then NOT A=0 -> Y=8'h23, then 8'h0F, on consecutive cycles.

Source files
------------

// File: rtl/alu.sv
// Registered two-operand ALU: 8 opcodes, 2*WIDTH-bit result one cycle after in_valid.
// Define ALU_FLAGS_EN to add registered zero/carry/neg flag outputs.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         sel,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] Y,
  output logic               out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic               zero,
  output logic               carry,
  output logic               neg
`endif
);

  localparam int RW = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  logic [RW-1:0] a_ext, b_ext, result;
  logic          carry_next;

  assign a_ext = {{WIDTH{1'b0}}, A};
  assign b_ext = {{WIDTH{1'b0}}, B};

  // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
  always_comb begin
    result     = '0;
    carry_next = 1'b0;
    case (op_e'(sel))
      OP_ADD: begin
        result     = a_ext + b_ext;
        carry_next = result[WIDTH];
      end
      OP_SUB: begin
        result     = a_ext - b_ext;
        carry_next = (A < B);
      end
      OP_AND: result = a_ext & b_ext;
      OP_OR:  result = a_ext | b_ext;
      OP_XOR: result = a_ext ^ b_ext;
      OP_NOT: result = {{WIDTH{1'b0}}, ~A};
      OP_MUL: result = a_ext * b_ext;
      OP_CMP: begin
        result[0] = (A > B);
        result[1] = (A == B);
        result[2] = (A < B);
      end
      default: result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Y <= result;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero  <= 1'b0;
      carry <= 1'b0;
      neg   <= 1'b0;
    end else if (in_valid) begin
      zero  <= (result == '0);
      carry <= carry_next;
      neg   <= result[RW-1];
    end
  end
`else
  // Flag logic is absent in this build; carry_next is intentionally unused.
  logic unused_carry;
  assign unused_carry = carry_next;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=4); flag checks follow ALU_FLAGS_EN.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [2:0] sel = '0;
  logic       in_valid = 1'b0;
  logic [7:0] Y;
  logic       out_valid;
`ifdef ALU_FLAGS_EN
  logic       zero, carry, neg;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel), .in_valid(in_valid),
    .Y(Y), .out_valid(out_valid)
`ifdef ALU_FLAGS_EN
    , .zero(zero), .carry(carry), .neg(neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation at the falling edge, then check result just after the rising edge.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] s, input logic [7:0] exp_y);
    @(negedge clk);
    A = a; B = b; sel = s; in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, ".Y"}, {8'h00, Y}, {8'h00, exp_y});
    check({tag, ".vld"}, {15'h0, out_valid}, 16'h1);
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h09, 8'h03, 8'h02, 8'h07, 8'h05, 8'h09, 8'h12, 8'h01};

    // Reset from idle
    #2 rst = 1'b1;
    #1;
    check("rst.Y", {8'h00, Y}, 16'h0);
    check("rst.vld", {15'h0, out_valid}, 16'h0);
`ifdef ALU_FLAGS_EN
    check("rst.flags", {13'h0, zero, carry, neg}, 16'h0);
`endif
    @(negedge clk); rst = 1'b0;

    // Opcode sweep with A=6, B=3, one per cycle
    for (int i = 0; i < 8; i++)
      run_op($sformatf("sweep%0d", i), 4'd6, 4'd3, 3'(i), sweep_exp[i]);

    // A=3, B=6
    run_op("sub36", 4'd3, 4'd6, 3'b001, 8'hFD);
`ifdef ALU_FLAGS_EN
    check("sub36.flags", {13'h0, zero, carry, neg}, 16'b011);
`endif
    run_op("cmp36", 4'd3, 4'd6, 3'b111, 8'h04);

    // Max operands
    run_op("addFF", 4'hF, 4'hF, 3'b000, 8'h1E);
`ifdef ALU_FLAGS_EN
    check("addFF.flags", {13'h0, zero, carry, neg}, 16'b010);
`endif
    run_op("mulFF", 4'hF, 4'hF, 3'b110, 8'hE1);
    run_op("cmpFF", 4'hF, 4'hF, 3'b111, 8'h02);
    run_op("xorFF", 4'hF, 4'hF, 3'b100, 8'h00);
`ifdef ALU_FLAGS_EN
    check("xorFF.flags", {13'h0, zero, carry, neg}, 16'b100);
`endif

    // Zero operands
    run_op("mul00", 4'h0, 4'h0, 3'b110, 8'h00);
    run_op("cmp00", 4'h0, 4'h0, 3'b111, 8'h02);

    // Hold for 3 idle cycles while inputs wander
    run_op("pre_hold", 4'd9, 4'd4, 3'b011, 8'h0D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      A = 4'(i * 5 + 1); B = 4'(15 - i); sel = 3'(i + 5);
      @(posedge clk); #1;
      check($sformatf("hold%0d.Y", i), {8'h00, Y}, 16'h000D);
      check($sformatf("hold%0d.vld", i), {15'h0, out_valid}, 16'h0);
    end

    // Back-to-back
    run_op("b2b_mul", 4'd5, 4'd7, 3'b110, 8'h23);
    run_op("b2b_not", 4'd0, 4'd9, 3'b101, 8'h0F);

    // Reset mid-cycle with in_valid high aborts the pending op
    @(negedge clk);
    A = 4'd2; B = 4'd3; sel = 3'b110; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("abort.Y", {8'h00, Y}, 16'h0);
    check("abort.vld", {15'h0, out_valid}, 16'h0);
    @(posedge clk); #1;
    check("abort_hold.Y", {8'h00, Y}, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst%0d.vld", i), {15'h0, out_valid}, 16'h0);
      check($sformatf("post_rst%0d.Y", i), {8'h00, Y}, 16'h0);
    end

    // Resume after reset
    run_op("resume", 4'd2, 4'd3, 3'b110, 8'h06);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("resume_end.vld", {15'h0, out_valid}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
